// File: rtl/cam_pkg.sv
// Shared CAM sizing constants and types used by the allocator, the write
// decoder and the CAM array.
package cam_pkg;

    localparam int CAM_DEPTH = 32;
    localparam int CAM_IDX_W = 5;

    typedef logic [CAM_IDX_W-1:0] cam_idx_t;
    typedef logic [CAM_DEPTH-1:0] cam_vec_t;

endpackage

// File: rtl/cam_free_prio_enc.sv
// Lowest-zero priority encoder: finds the first free entry in a valid vector
// and flags whether any entry is free at all.
module cam_free_prio_enc
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int IDX_W = CAM_IDX_W
) (
    input  logic [DEPTH-1:0] i_valid,
    output logic [IDX_W-1:0] o_free_idx,
    output logic             o_any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_free_idx = '0;
        o_any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_free_idx = IDX_W'(i);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_write_alloc.sv
// CAM write-path allocator: picks the lowest free entry, or a round-robin
// victim when full, and drives a registered write strobe/index to the decoder.
module cam_write_alloc
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int IDX_W = CAM_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req_i,
    output logic             alloc_ready_o,
    input  logic             inval_i,
    input  logic [IDX_W-1:0] inval_index_i,
    input  logic             flush_i,
    output logic             write_enable_o,
    output logic [IDX_W-1:0] write_index_o,
    output logic             evict_o,
    output logic [DEPTH-1:0] valid_o,
    output logic [IDX_W:0]   count_o,
    output logic             full_o
);

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   ONE_COUNT  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W:0]   r_count;
    logic             r_full;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_we;
    logic [IDX_W-1:0] r_idx;
    logic             r_evict;

    logic             w_ready;
    logic             w_accept;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_any_free;
    logic [IDX_W-1:0] w_victim;
    logic             w_evict;
    logic             w_inval_eff;
    logic [DEPTH-1:0] w_valid_next;
    logic [IDX_W:0]   w_count_next;

    cam_free_prio_enc #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_free_enc (
        .i_valid    (r_valid),
        .o_free_idx (w_free_idx),
        .o_any_free (w_any_free)
    );

    assign w_ready  = ~reset & ~flush_i;
    assign w_accept = alloc_req_i & w_ready;
    assign w_evict  = ~w_any_free;
    assign w_victim = w_any_free ? w_free_idx : r_rr_ptr;

    // An invalidate aimed at the entry being allocated loses to the allocation.
    assign w_inval_eff = inval_i & r_valid[inval_index_i]
                       & ~(w_accept & (inval_index_i == w_victim));

    always_comb begin
        w_valid_next = r_valid;
        if (inval_i) begin
            w_valid_next[inval_index_i] = 1'b0;
        end
        if (w_accept) begin
            w_valid_next[w_victim] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_evict) begin
            w_count_next = w_count_next + ONE_COUNT;
        end
        if (w_inval_eff) begin
            w_count_next = w_count_next - ONE_COUNT;
        end
    end

    // Flush clears occupancy and the victim pointer but leaves the last write
    // index untouched; the decoder only looks at it under a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_evict  <= 1'b0;
        end else if (flush_i) begin
            r_valid  <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_evict  <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_we    <= w_accept;
            r_evict <= w_accept & w_evict;
            if (w_accept) begin
                r_idx <= w_victim;
            end
            if (w_accept && w_evict) begin
                r_rr_ptr <= r_rr_ptr + ONE_IDX;
            end
        end
    end

    assign alloc_ready_o  = w_ready;
    assign write_enable_o = r_we;
    assign write_index_o  = r_idx;
    assign evict_o        = r_evict;
    assign valid_o        = r_valid;
    assign count_o        = r_count;
    assign full_o         = r_full;

endmodule

// File: doc/cam_write_alloc.md
Name: cam_write_alloc

Overview:
- Upstream allocation stage for the 32-entry CAM write path. It chooses which entry a new key is written into.
- Tracks per-entry valid bits. Picks the lowest-index free entry; when the CAM is full, evicts a round-robin victim.
- Drives a registered write-enable/index pair straight into the CAM write-address decoder.
- Also supports single-entry invalidate and full flush.

Parameters:
- DEPTH, 32, number of CAM entries; must be a power of two.
- IDX_W, 5, index width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- alloc_req_i  input  1  request to allocate one entry this cycle.
- alloc_ready_o  output  1  allocator can accept a request this cycle.
- inval_i  input  1  invalidate one entry.
- inval_index_i  input  IDX_W  entry to invalidate.
- flush_i  input  1  invalidate all entries.
- write_enable_o  output  1  write strobe to the decoder; registered.
- write_index_o  output  IDX_W  entry being written; registered.
- evict_o  output  1  the current write overwrites a valid entry; registered.
- valid_o  output  DEPTH  per-entry valid vector.
- count_o  output  IDX_W+1  number of valid entries, range 0..DEPTH.
- full_o  output  1  all entries valid.

Behaviour:
- Reset values:
  - write_enable_o=0, write_index_o=0, evict_o=0.
  - valid_o=0, count_o=0, full_o=0.
  - Round-robin victim pointer rr_ptr=0. alloc_ready_o=0 during the reset cycle.
- Priority: reset > flush_i > (alloc, inval).
- Accept:
  - A request is accepted when alloc_req_i & alloc_ready_o.
  - alloc_ready_o=1 in every cycle except reset and flush_i cycles. It has no combinational dependence on alloc_req_i.
- Selection, combinational on the current (pre-edge) valid_o:
  - If any bit of valid_o is 0: victim = lowest index i with valid_o[i]=0; evict=0.
  - Else: victim = rr_ptr; evict=1; rr_ptr <= rr_ptr+1, wrapping from DEPTH-1 to 0.
  - rr_ptr changes only on eviction.
- Latency:
  - Accept in cycle N gives write_enable_o=1, write_index_o=victim and evict_o=evict in cycle N+1. valid_o[victim]=1 is also visible in N+1.
  - Back-to-back accepts yield consecutive write strobes; each selection sees the previous allocation's valid bit.
- No accept in cycle N: write_enable_o=0 and evict_o=0 in N+1. write_index_o holds its last value.
- Invalidate: inval_i in cycle N clears valid_o[inval_index_i] in N+1. Invalidating an already-invalid entry has no effect.
- Same cycle, inval_index_i == victim: the allocation wins, so valid stays 1 and the count reflects the net result.
- Same cycle, different indices: both take effect. The selection still uses the pre-edge valid_o, so a freshly freed entry is not usable until the next cycle.
- Flush:
  - flush_i in cycle N gives valid_o=0, count_o=0 and rr_ptr=0 in N+1. write_enable_o=0 in N+1.
  - alloc_req_i and inval_i are ignored in cycle N.
- count_o and full_o are registered, update in lockstep with valid_o, and never exceed DEPTH.
  - Per edge, count changes by +1 (alloc into a free entry), -1 (effective inval), 0 (both, or an eviction), or goes to 0 on flush.
- Reset mid-operation: all state returns to reset values on that edge. No write strobe appears in the following cycle.

Decomposition:
- Shared package cam_pkg:
  - Constants CAM_DEPTH=32 and CAM_IDX_W=5.
  - Typedefs cam_idx_t (logic [CAM_IDX_W-1:0]) and cam_vec_t (logic [CAM_DEPTH-1:0]).
  - Used by this block, the decoder and the CAM array.
- One sub-module: cam_free_prio_enc.
  - Combinational lowest-zero priority encoder over cam_vec_t.
  - Outputs the index and an any_free flag.

Test Plan:
- Reset, then 32 consecutive accepted requests -> write_index_o = 0,1,...,31 on successive cycles, evict_o=0 throughout. After the last strobe: full_o=1, count_o=32, valid_o=32'hFFFF_FFFF.
- Full CAM, 3 more requests -> write_index_o = 0, 1, 2 with evict_o=1. count_o stays 32; rr_ptr ends at 3.
- Full CAM, inval_i with index 7, then a request next cycle -> count_o=31 after the inval. The alloc writes index 7 with evict_o=0; count_o returns to 32.
- valid_o=32'h0000_FFFF, alloc and inval of index 3 in the same cycle -> write_index_o=16 and valid_o=32'h0001_FFF7 next cycle; count_o unchanged at 16.
- valid_o=32'h0000_00FF, alloc and inval of index 8 in the same cycle (8 is the victim) -> write_index_o=8, valid_o[8]=1, count_o=9.
- Full CAM with rr_ptr=5, flush_i asserted together with alloc_req_i -> no strobe next cycle; valid_o=0, count_o=0, alloc_ready_o=0 during the flush cycle. The next request writes index 0; after refilling, the first eviction hits index 0.
- Assert reset one cycle after an accepted request -> no write strobe after reset; all outputs at reset values.
